sdram_stream_gen_t1: RTL and testbench

- Test-pattern source for the SDRAM streaming path: produces a 32-bit incrementing counter as a stream of 16-bit words, high half first, then low half.
- Output feeds the SDRAM write side, so the stream-check type-1 error checker at the far end sees groups of 4 words that form two values, with snd == fst + 1.
- Flow control comes from a downstream ready signal.
- Controlled error injection lets the bench exercise the checker.

---
 rtl/sdram_stream_gen_t1.sv | 89 ++++++++
 tb/tb_sdram_stream_gen_t1.sv | 106 ++++++++++
 2 files changed

// File: rtl/sdram_stream_gen_t1.sv
// sdram_stream_gen_t1: 32-bit incrementing counter streamed as 16-bit words (high half first), ending runs on pair boundaries.
module sdram_stream_gen_t1 #(
    parameter logic [31:0] START_VALUE = 32'h0000_0000,
    parameter logic [31:0] STEP        = 32'h0000_0001,
    parameter logic [31:0] NUM_VALUES  = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        ready_i,
    input  logic        inject_err_i,
    output logic [15:0] data_o,
    output logic        wren_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] value_cnt_o
);
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d, cnt_q, cnt_d, cnt_inc;
    logic [15:0] data_q, data_d;
    logic        wren_q, wren_d, stop_q, stop_d, err_q, err_d, busy, stop_now, err_now;

    assign busy     = (state_q == SEND_HI) || (state_q == SEND_LO);
    assign stop_now = busy && (stop_i || stop_q);
    assign err_now  = busy && (inject_err_i || err_q);
    assign cnt_inc  = cnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        stop_d  = stop_now;
        err_d   = err_now;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                value_d = START_VALUE;
                cnt_d   = '0;
                stop_d  = 1'b0;
                err_d   = 1'b0;
                state_d = SEND_HI;
            end
            SEND_HI: if (ready_i) begin
                data_d  = value_q[31:16];
                wren_d  = 1'b1;
                state_d = SEND_LO;
            end
            default: if (ready_i) begin
                data_d  = value_q[15:0];
                wren_d  = 1'b1;
                cnt_d   = cnt_inc;
                // Skipping a value right after fst makes the checker see snd != fst + 1.
                value_d = (err_now && !cnt_q[0]) ? value_q + STEP * 32'd2 : value_q + STEP;
                err_d   = err_now && cnt_q[0];
                state_d = (!cnt_inc[0] && (stop_now || (NUM_VALUES != 0 && cnt_inc == NUM_VALUES))) ? DONE : SEND_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= START_VALUE;
            cnt_q   <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
        end
    end

    assign data_o      = data_q;
    assign wren_o      = wren_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign value_cnt_o = cnt_q;
endmodule

// File: tb/tb_sdram_stream_gen_t1.sv
// tb_sdram_stream_gen_t1: scoreboard bench; directed runs push expected words, a negedge monitor pops and compares.
module tb_sdram_stream_gen_t1;
    logic        clk = 0, rst = 1, start = 0, start_w = 0, stop = 0, ready = 1, inject = 0, zero = 0;
    logic [15:0] data, data_w;
    logic        wren, wren_w, busy, busy_w, done, done_w;
    logic [31:0] vcnt, vcnt_w;
    logic [15:0] q0[$], qw[$];
    int          checks = 0, failures = 0, cyc;

    always #5 clk = ~clk;

    sdram_stream_gen_t1 #(.START_VALUE(32'h0), .STEP(32'h1), .NUM_VALUES(32'd6)) dut (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .ready_i(ready), .inject_err_i(inject),
        .data_o(data), .wren_o(wren), .busy_o(busy), .done_o(done), .value_cnt_o(vcnt));

    sdram_stream_gen_t1 #(.START_VALUE(32'hFFFF_FFFE), .STEP(32'h1), .NUM_VALUES(32'd4)) dut_w (
        .clk(clk), .rst(rst), .start_i(start_w), .stop_i(zero), .ready_i(ready), .inject_err_i(zero),
        .data_o(data_w), .wren_o(wren_w), .busy_o(busy_w), .done_o(done_w), .value_cnt_o(vcnt_w));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v, input bit w);
        if (w) begin qw.push_back(v[31:16]); qw.push_back(v[15:0]); end
        else begin q0.push_back(v[31:16]); q0.push_back(v[15:0]); end
    endtask

    always @(negedge clk) begin
        if (wren) begin
            if (q0.size() == 0) chk("unexpected_word", {16'h0, data}, 32'hDEAD_BEEF);
            else chk("word", {16'h0, data}, {16'h0, q0.pop_front()});
        end
        if (wren_w) begin
            if (qw.size() == 0) chk("unexpected_word_w", {16'h0, data_w}, 32'hDEAD_BEEF);
            else chk("word_w", {16'h0, data_w}, {16'h0, qw.pop_front()});
        end
    end

    task automatic run(input bit alt, input int inj_at, input int stop_at, input int exp_cyc, input int exp_cnt, input bit both);
        @(posedge clk); #1 start = 1; start_w = both; ready = 1;
        @(posedge clk); #1 start = 0; start_w = 0; cyc = 0;
        chk("done_clear_on_start", {31'h0, done}, 32'h0);
        while (!done && cyc < 200) begin
            @(posedge clk); cyc++; #1;
            if (alt) ready = !ready;
            inject = (cyc == inj_at);
            stop   = (cyc == stop_at);
        end
        inject = 0; stop = 0; ready = 1;
        chk("run_cycles", cyc, exp_cyc);
        @(posedge clk); #1;
        chk("done", {31'h0, done}, 32'h1);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk("wren_after", {31'h0, wren}, 32'h0);
        chk("value_cnt", vcnt, exp_cnt);
        chk("queue_drained", q0.size(), 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_data", {16'h0, data}, 32'h0);
        chk("rst_wren", {31'h0, wren}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_cnt", vcnt, 32'h0);
        // Basic run plus wrap-around run on the second instance.
        for (int i = 0; i < 6; i++) push(i, 0);
        push(32'hFFFF_FFFE, 1); push(32'hFFFF_FFFF, 1); push(32'h0, 1); push(32'h1, 1);
        run(0, -1, -1, 12, 6, 1);
        chk("wrap_done", {31'h0, done_w}, 32'h1);
        chk("wrap_cnt", vcnt_w, 32'd4);
        chk("wrap_drained", qw.size(), 32'h0);
        // Alternating ready: 12 words over 23 edges after start.
        for (int i = 0; i < 6; i++) push(i, 0);
        run(1, -1, -1, 23, 6, 0);
        // Error injection during value 2's high word skips value 3.
        push(0, 0); push(1, 0); push(2, 0); push(4, 0); push(5, 0); push(6, 0);
        run(0, 4, -1, 12, 6, 0);
        // Stop during value 1's high word, then during value 2.
        push(0, 0); push(1, 0);
        run(0, -1, 2, 4, 2, 0);
        for (int i = 0; i < 4; i++) push(i, 0);
        run(0, -1, 4, 8, 4, 0);
        // Reset between the high and low word of value 0.
        q0.push_back(16'h0000);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("midrst_wren", {31'h0, wren}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_cnt", vcnt, 32'h0);
        for (int i = 0; i < 6; i++) push(i, 0);
        run(0, -1, -1, 12, 6, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
